// File: rtl/fp_pkg.sv
// Shared types and helpers for the pipelined floating-point adder.
package fp_pkg;

  typedef enum logic [1:0] {
    FP_ZERO = 2'd0,
    FP_NORM = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_e;

  function automatic int unsigned bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 32'd1)) - 32'd1;
  endfunction

  // Subnormals classify as zero: the adder flushes them on entry.
  function automatic fp_class_e classify(input logic exp_ones, input logic exp_zero,
                                         input logic frac_nz);
    if (exp_ones) return frac_nz ? FP_NAN : FP_INF;
    if (exp_zero) return FP_ZERO;
    return FP_NORM;
  endfunction

  function automatic logic [127:0] qnan_bits(input int unsigned exp_w, input int unsigned man_w);
    logic [127:0] one;
    one = 128'd1;
    return (((one << exp_w) - one) << man_w) | (one << (man_w - 32'd1));
  endfunction

  function automatic logic rne_up(input logic lsb, input logic g, input logic r, input logic s);
    return g & (r | s | lsb);
  endfunction

endpackage

// File: rtl/fp_norm_shift.sv
// Leading-zero count and normalising left shift for the final adder stage.
module fp_norm_shift #(
  parameter int unsigned WIDTH = 27,
  localparam int unsigned LZ_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [LZ_W-1:0]  lzc_c,
  output logic [WIDTH-1:0] dout_c
);

  // Highest set bit wins since the scan runs upward.
  always_comb begin
    lzc_c = LZ_W'(WIDTH);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (din[i]) lzc_c = LZ_W'(int'(WIDTH) - 1 - i);
    end
    dout_c = din << lzc_c;
  end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage IEEE-754-style adder/subtractor (align, add, normalise/round)
// with valid/ready flow control and per-result exception flags.
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_ovf,
  output logic         out_unf,
  output logic         out_nan
);

  localparam int unsigned ML   = MAN_W + 4;
  localparam int unsigned EW   = EXP_W + 2;
  localparam int unsigned LZ_W = $clog2(ML + 1);
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic [W-1:0]         QNAN     = W'(qnan_bits(EXP_W, MAN_W));
  localparam logic signed [EW-1:0] EMAX     = $signed(EW'((1 << EXP_W) - 1));

  logic en;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // stage 1 combinational: classify, pick larger magnitude, align smaller
  logic            sa, sb, a_big;
  logic [EXP_W-1:0] ea, eb, diff;
  logic [MAN_W-1:0] fa, fb;
  logic [ML-1:0]   man_a, man_b, m_sml;
  logic [2*ML-1:0] ext;
  fp_class_e       ca, cb;
  fp_class_e       c1_cls;
  logic            c1_sign;
  logic [EXP_W-1:0] c1_exp;
  logic [ML-1:0]   c1_mb, c1_ms;

  always_comb begin
    sa      = in_a[W-1];
    sb      = in_b[W-1] ^ in_sub;
    ea      = in_a[W-2:MAN_W];
    eb      = in_b[W-2:MAN_W];
    fa      = (ea == '0) ? '0 : in_a[MAN_W-1:0];
    fb      = (eb == '0) ? '0 : in_b[MAN_W-1:0];
    ca      = classify(ea == EXP_ONES, ea == '0, in_a[MAN_W-1:0] != '0);
    cb      = classify(eb == EXP_ONES, eb == '0, in_b[MAN_W-1:0] != '0);
    man_a   = {ea != '0, fa, 3'b000};
    man_b   = {eb != '0, fb, 3'b000};
    a_big   = {ea, fa} >= {eb, fb};
    c1_exp  = a_big ? ea : eb;
    diff    = a_big ? (ea - eb) : (eb - ea);
    c1_mb   = a_big ? man_a : man_b;
    m_sml   = a_big ? man_b : man_a;
    ext     = {m_sml, {ML{1'b0}}} >> diff;
    if (32'(diff) >= ML) c1_ms = {{(ML-1){1'b0}}, |m_sml};
    else                 c1_ms = {ext[2*ML-1:ML+1], ext[ML] | (|ext[ML-1:0])};
    c1_cls  = FP_NORM;
    c1_sign = a_big ? sa : sb;
    if (ca == FP_NAN || cb == FP_NAN || (ca == FP_INF && cb == FP_INF && sa != sb)) begin
      c1_cls  = FP_NAN;
      c1_sign = 1'b0;
    end else if (ca == FP_INF) begin
      c1_cls  = FP_INF;
      c1_sign = sa;
    end else if (cb == FP_INF) begin
      c1_cls  = FP_INF;
      c1_sign = sb;
    end else if (ca == FP_ZERO && cb == FP_ZERO) begin
      c1_cls  = FP_ZERO;
      c1_sign = sa & sb;
    end
  end

  logic             s1_valid, s1_sign, s1_sub;
  fp_class_e        s1_cls;
  logic [EXP_W-1:0] s1_exp;
  logic [ML-1:0]    s1_mb, s1_ms;

  // stage 2 combinational: magnitude add or subtract
  logic [ML:0]            sum;
  logic [ML-1:0]          c2_man;
  logic signed [EW-1:0]   c2_exp;

  always_comb begin
    sum    = {1'b0, s1_mb} + {1'b0, s1_ms};
    c2_man = sum[ML-1:0];
    c2_exp = EW'(s1_exp);
    if (s1_sub) begin
      c2_man = s1_mb - s1_ms;
    end else if (sum[ML]) begin
      c2_man = {sum[ML:2], sum[1] | sum[0]};
      c2_exp = EW'(s1_exp) + EW'(1);
    end
  end

  logic                 s2_valid, s2_sign;
  fp_class_e            s2_cls;
  logic signed [EW-1:0] s2_exp;
  logic [ML-1:0]        s2_man;

  // stage 3 combinational: normalise, round, range check, specials
  logic [LZ_W-1:0]      lzc;
  logic [ML-1:0]        nman;
  logic                 up;
  logic [MAN_W+1:0]     rman;
  logic signed [EW-1:0] e3;
  logic [MAN_W-1:0]     frac;
  logic [W-1:0]         r_sum;
  logic                 r_ovf, r_unf, r_nan;

  fp_norm_shift #(.WIDTH(ML)) u_norm (
    .din    (s2_man),
    .lzc_c  (lzc),
    .dout_c (nman)
  );

  always_comb begin
    up    = rne_up(nman[3], nman[2], nman[1], nman[0]);
    rman  = {1'b0, nman[ML-1:3]} + (MAN_W+2)'(up);
    e3    = s2_exp - EW'(lzc) + EW'(rman[MAN_W+1]);
    frac  = rman[MAN_W+1] ? '0 : rman[MAN_W-1:0];
    r_sum = '0;
    r_ovf = 1'b0;
    r_unf = 1'b0;
    r_nan = 1'b0;
    case (s2_cls)
      FP_NAN: begin
        r_sum = QNAN;
        r_nan = 1'b1;
      end
      FP_INF:  r_sum = {s2_sign, EXP_ONES, MAN_W'(0)};
      FP_ZERO: r_sum = {s2_sign, (W-1)'(0)};
      default: begin
        // exact cancellation leaves no hidden bit and yields +0
        if (!(rman[MAN_W+1] || rman[MAN_W])) begin
          r_sum = '0;
        end else if (e3 >= EMAX) begin
          r_sum = {s2_sign, EXP_ONES, MAN_W'(0)};
          r_ovf = 1'b1;
        end else if (e3[EW-1] || e3 == '0) begin
          r_sum = {s2_sign, (W-1)'(0)};
          r_unf = 1'b1;
        end else begin
          r_sum = {s2_sign, e3[EXP_W-1:0], frac};
        end
      end
    endcase
  end

  // pipeline registers; everything holds while the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_cls    <= FP_ZERO;
      s1_sign   <= 1'b0;
      s1_sub    <= 1'b0;
      s1_exp    <= '0;
      s1_mb     <= '0;
      s1_ms     <= '0;
      s2_valid  <= 1'b0;
      s2_cls    <= FP_ZERO;
      s2_sign   <= 1'b0;
      s2_exp    <= '0;
      s2_man    <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
      out_nan   <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_cls    <= c1_cls;
      s1_sign   <= c1_sign;
      s1_sub    <= sa ^ sb;
      s1_exp    <= c1_exp;
      s1_mb     <= c1_mb;
      s1_ms     <= c1_ms;
      s2_valid  <= s1_valid;
      s2_cls    <= s1_cls;
      s2_sign   <= s1_sign;
      s2_exp    <= c2_exp;
      s2_man    <= c2_man;
      out_valid <= s2_valid;
      out_sum   <= r_sum;
      out_ovf   <= s2_valid & r_ovf;
      out_unf   <= s2_valid & r_unf;
      out_nan   <= s2_valid & r_nan;
    end
  end

endmodule
